// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control sequencer: walks the shared datapath through
// FETCH/DECODE/EXEC/MEM/WB per instruction and counts retired instructions.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  OpCode,
    input  logic [5:0]  funct,
    input  logic        Zero,
    input  logic        mem_ready,
    output logic        PCWr,
    output logic        PCWrCond,
    output logic        IorD,
    output logic        IRWr,
    output logic        MemR,
    output logic        MemW,
    output logic        RegW,
    output logic        RegDst,
    output logic        Mem2R,
    output logic        AluSrcA,
    output logic [1:0]  AluSrcB,
    output logic [1:0]  PCSrc,
    output logic [1:0]  ExtOp,
    output logic [4:0]  Aluctrl,
    output logic        illegal,
    output logic [31:0] instr_cnt
);

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGNED = 2'b01;

    localparam logic [4:0] ALUOP_NOP  = 5'd0;
    localparam logic [4:0] ALUOP_ADDU = 5'd1;
    localparam logic [4:0] ALUOP_ADD  = 5'd2;
    localparam logic [4:0] ALUOP_SUBU = 5'd3;
    localparam logic [4:0] ALUOP_SUB  = 5'd4;
    localparam logic [4:0] ALUOP_OR   = 5'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I,
        S_MEMADR, S_MEMRD, S_WB_MEM, S_MEMWR, S_BRANCH, S_JUMP
    } state_e;

    typedef enum logic [2:0] {
        C_ADDU, C_SUBU, C_ORI, C_LW, C_SW, C_BEQ, C_J, C_ILL
    } cls_e;

    typedef struct packed {
        logic       pcwr;
        logic       pcwrcond;
        logic       iord;
        logic       fetch_en;
        logic       memr;
        logic       memw;
        logic       regw;
        logic       regdst;
        logic       mem2r;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] extop;
        logic [4:0] aluctrl;
    } ctrl_t;

    state_e      state_q, state_d;
    cls_e        cls_q, cls_d, cls_now;
    ctrl_t       ctrl_q, ctrl_d;
    logic        illegal_q;
    logic [31:0] cnt_q;
    logic        retire;

    // The datapath itself gates the branch PC write with Zero.
    logic unused_zero;
    assign unused_zero = Zero;

    function automatic ctrl_t decode_outputs(input state_e s, input cls_e c);
        ctrl_t o;
        o         = '0;
        o.extop   = EXT_ZERO;
        o.aluctrl = ALUOP_NOP;
        case (s)
            S_FETCH: begin
                o.memr     = 1'b1;
                o.fetch_en = 1'b1;
                o.alusrcb  = 2'b01;
                o.aluctrl  = ALUOP_ADDU;
            end
            S_DECODE: begin
                o.alusrcb = 2'b11;
                o.extop   = EXT_SIGNED;
                o.aluctrl = ALUOP_ADD;
            end
            S_EXEC_R: begin
                o.alusrca = 1'b1;
                o.aluctrl = (c == C_SUBU) ? ALUOP_SUBU : ALUOP_ADDU;
            end
            S_WB_R: begin
                o.regdst = 1'b1;
                o.regw   = 1'b1;
            end
            S_EXEC_I: begin
                o.alusrca = 1'b1;
                o.alusrcb = 2'b10;
                o.aluctrl = ALUOP_OR;
            end
            S_WB_I: o.regw = 1'b1;
            S_MEMADR: begin
                o.alusrca = 1'b1;
                o.alusrcb = 2'b10;
                o.extop   = EXT_SIGNED;
                o.aluctrl = ALUOP_ADD;
            end
            S_MEMRD: begin
                o.iord = 1'b1;
                o.memr = 1'b1;
            end
            S_WB_MEM: begin
                o.mem2r = 1'b1;
                o.regw  = 1'b1;
            end
            S_MEMWR: begin
                o.iord = 1'b1;
                o.memw = 1'b1;
            end
            S_BRANCH: begin
                o.alusrca  = 1'b1;
                o.aluctrl  = ALUOP_SUB;
                o.pcwrcond = 1'b1;
                o.pcsrc    = 2'b01;
            end
            S_JUMP: begin
                o.pcwr  = 1'b1;
                o.pcsrc = 2'b10;
            end
            default: ;
        endcase
        return o;
    endfunction

    always_comb begin
        cls_now = C_ILL;
        case (OpCode)
            6'b000000: begin
                if (funct == 6'b100001)      cls_now = C_ADDU;
                else if (funct == 6'b100011) cls_now = C_SUBU;
            end
            6'b001101: cls_now = C_ORI;
            6'b100011: cls_now = C_LW;
            6'b101011: cls_now = C_SW;
            6'b000100: cls_now = C_BEQ;
            6'b000010: cls_now = C_J;
            default:   cls_now = C_ILL;
        endcase
    end

    // NOTE: every signal written here gets a default first, otherwise a
    // path that skips the assignment infers a latch.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                cls_d = cls_now;
                case (cls_now)
                    C_ADDU, C_SUBU: state_d = S_EXEC_R;
                    C_ORI:          state_d = S_EXEC_I;
                    C_LW, C_SW:     state_d = S_MEMADR;
                    C_BEQ:          state_d = S_BRANCH;
                    C_J:            state_d = S_JUMP;
                    default:        state_d = S_FETCH;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_EXEC_I: state_d = S_WB_I;
            S_MEMADR: state_d = (cls_q == C_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_WB_MEM;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_WB_R, S_WB_I, S_WB_MEM, S_BRANCH, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase

        // Outputs are decoded from the state being entered so they come
        // straight off flops in that state.
        ctrl_d = decode_outputs(state_d, cls_d);

        retire = (state_q == S_WB_R) || (state_q == S_WB_I) ||
                 (state_q == S_WB_MEM) || (state_q == S_BRANCH) ||
                 (state_q == S_JUMP) || ((state_q == S_MEMWR) && mem_ready);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cls_q     <= C_ILL;
            ctrl_q    <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            ctrl_q    <= ctrl_d;
            illegal_q <= (state_q == S_DECODE) && (cls_now == C_ILL);
            if (retire) cnt_q <= cnt_q + 32'd1;
        end
    end

    // Fetch write strobes fire only in the cycle the memory delivers the word.
    assign IRWr      = ctrl_q.fetch_en & mem_ready;
    assign PCWr      = ctrl_q.pcwr | (ctrl_q.fetch_en & mem_ready);
    assign PCWrCond  = ctrl_q.pcwrcond;
    assign IorD      = ctrl_q.iord;
    assign MemR      = ctrl_q.memr;
    assign MemW      = ctrl_q.memw;
    assign RegW      = ctrl_q.regw;
    assign RegDst    = ctrl_q.regdst;
    assign Mem2R     = ctrl_q.mem2r;
    assign AluSrcA   = ctrl_q.alusrca;
    assign AluSrcB   = ctrl_q.alusrcb;
    assign PCSrc     = ctrl_q.pcsrc;
    assign ExtOp     = ctrl_q.extop;
    assign Aluctrl   = ctrl_q.aluctrl;
    assign illegal   = illegal_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction model of cycle
// counts, strobe counts and per-phase control values, with random waits.
module tb_multicycle_ctrl;

    localparam logic [1:0] EXT_ZERO   = 2'b00;
    localparam logic [1:0] EXT_SIGNED = 2'b01;
    localparam logic [4:0] ALU_ADDU = 5'd1;
    localparam logic [4:0] ALU_ADD  = 5'd2;
    localparam logic [4:0] ALU_SUBU = 5'd3;
    localparam logic [4:0] ALU_SUB  = 5'd4;
    localparam logic [4:0] ALU_OR   = 5'd5;

    typedef enum {K_ADDU, K_SUBU, K_ORI, K_LW, K_SW, K_BEQ, K_J, K_ILL} kind_e;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  OpCode, funct;
    logic        Zero, mem_ready;
    logic        PCWr, PCWrCond, IorD, IRWr, MemR, MemW, RegW, RegDst, Mem2R, AluSrcA;
    logic [1:0]  AluSrcB, PCSrc, ExtOp;
    logic [4:0]  Aluctrl;
    logic        illegal;
    logic [31:0] instr_cnt;
    logic [53:0] all_out;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = '0;

    always #5 clk = ~clk;

    assign all_out = {PCWr, PCWrCond, IorD, IRWr, MemR, MemW, RegW, RegDst, Mem2R,
                      AluSrcA, AluSrcB, PCSrc, ExtOp, Aluctrl, illegal, instr_cnt};

    multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .OpCode(OpCode), .funct(funct), .Zero(Zero),
        .mem_ready(mem_ready), .PCWr(PCWr), .PCWrCond(PCWrCond), .IorD(IorD),
        .IRWr(IRWr), .MemR(MemR), .MemW(MemW), .RegW(RegW), .RegDst(RegDst),
        .Mem2R(Mem2R), .AluSrcA(AluSrcA), .AluSrcB(AluSrcB), .PCSrc(PCSrc),
        .ExtOp(ExtOp), .Aluctrl(Aluctrl), .illegal(illegal), .instr_cnt(instr_cnt)
    );

    function automatic kind_e classify(input logic [5:0] op, input logic [5:0] fn);
        if (op == 6'b000000 && fn == 6'b100001) return K_ADDU;
        if (op == 6'b000000 && fn == 6'b100011) return K_SUBU;
        if (op == 6'b001101) return K_ORI;
        if (op == 6'b100011) return K_LW;
        if (op == 6'b101011) return K_SW;
        if (op == 6'b000100) return K_BEQ;
        if (op == 6'b000010) return K_J;
        return K_ILL;
    endfunction

    // Runs one instruction starting at a negedge in FETCH; ends at the negedge
    // of the following instruction's first cycle.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic zero_v, input string name);
        kind_e k;
        int n_cyc, n_irwr, n_regw, n_pcwr, n_pcwrc, n_memw_done, n_dec;
        int n_fetch, n_memr_d, n_memw_c, n_imm, n_rr, acc_idx, waits;
        int e_regw, e_pcwr, e_pcwrc, e_memw_done, e_memr_d, e_memw_c, e_imm, e_rr;
        bit acc_prev, rdy_prev, acc_now, is_r, is_mem;
        k = classify(op, fn);
        is_r   = (k == K_ADDU) || (k == K_SUBU);
        is_mem = (k == K_LW) || (k == K_SW);
        case (k)
            K_BEQ, K_J: n_cyc = 3;
            K_LW:       n_cyc = 5;
            K_ILL:      n_cyc = 2;
            default:    n_cyc = 4;
        endcase
        n_cyc       = n_cyc + fw + (is_mem ? mw : 0);
        e_regw      = (is_r || k == K_ORI || k == K_LW) ? 1 : 0;
        e_pcwr      = (k == K_J) ? 2 : 1;
        e_pcwrc     = (k == K_BEQ) ? 1 : 0;
        e_memw_done = (k == K_SW) ? 1 : 0;
        e_memr_d    = (k == K_LW) ? mw + 1 : 0;
        e_memw_c    = (k == K_SW) ? mw + 1 : 0;
        e_imm       = (k == K_ORI || is_mem) ? 1 : 0;
        e_rr        = (is_r || k == K_BEQ) ? 1 : 0;
        {n_irwr, n_regw, n_pcwr, n_pcwrc, n_memw_done, n_dec} = '0;
        {n_fetch, n_memr_d, n_memw_c, n_imm, n_rr, acc_idx, waits} = '0;
        acc_prev = 1'b0;
        rdy_prev = 1'b0;
        OpCode   = op;
        funct    = fn;
        Zero     = zero_v;
        for (int c = 0; c < n_cyc; c++) begin
            acc_now = MemR | MemW;
            if (acc_now && (!acc_prev || rdy_prev)) begin
                acc_idx++;
                waits = (acc_idx == 1) ? fw : mw;
            end
            if (acc_now) begin
                mem_ready = (waits == 0);
                if (waits > 0) waits--;
            end else begin
                mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            n_irwr  += int'(IRWr);
            n_regw  += int'(RegW);
            n_pcwr  += int'(PCWr);
            n_pcwrc += int'(PCWrCond);
            if (MemR && !IorD) begin
                n_fetch++;
                checks++;
                if (AluSrcA !== 1'b0 || AluSrcB !== 2'b01 || Aluctrl !== ALU_ADDU ||
                    PCSrc !== 2'b00 || IRWr !== mem_ready || PCWr !== mem_ready) begin
                    errors++;
                    $display("FAIL %s fetch_ctrl cyc%0d got A=%b B=%b alu=%0d pcsrc=%b irwr=%b pcwr=%b want A=0 B=01 alu=%0d pcsrc=00 irwr=pcwr=%b",
                             name, c, AluSrcA, AluSrcB, Aluctrl, PCSrc, IRWr, PCWr, ALU_ADDU, mem_ready);
                end
            end
            if (MemR && IorD) n_memr_d++;
            if (MemW) begin
                n_memw_c++;
                if (mem_ready) n_memw_done++;
            end
            if (RegW) begin
                checks++;
                if (RegDst !== is_r || Mem2R !== (k == K_LW)) begin
                    errors++;
                    $display("FAIL %s wb_sel got RegDst=%b Mem2R=%b want RegDst=%b Mem2R=%b",
                             name, RegDst, Mem2R, is_r, k == K_LW);
                end
            end
            if (PCWrCond) begin
                checks++;
                if (PCSrc !== 2'b01 || Aluctrl !== ALU_SUB) begin
                    errors++;
                    $display("FAIL %s branch got PCSrc=%b alu=%0d want PCSrc=01 alu=%0d",
                             name, PCSrc, Aluctrl, ALU_SUB);
                end
            end
            if (PCWr && !MemR) begin
                checks++;
                if (PCSrc !== 2'b10) begin
                    errors++;
                    $display("FAIL %s jump got PCSrc=%b want 10", name, PCSrc);
                end
            end
            if (AluSrcB == 2'b11) begin
                n_dec++;
                checks++;
                if (AluSrcA !== 1'b0 || ExtOp !== EXT_SIGNED || Aluctrl !== ALU_ADD) begin
                    errors++;
                    $display("FAIL %s decode got A=%b ext=%b alu=%0d want A=0 ext=%b alu=%0d",
                             name, AluSrcA, ExtOp, Aluctrl, EXT_SIGNED, ALU_ADD);
                end
            end
            if (AluSrcA && AluSrcB == 2'b00) begin
                n_rr++;
                checks++;
                if (Aluctrl !== ((k == K_ADDU) ? ALU_ADDU : (k == K_SUBU) ? ALU_SUBU : ALU_SUB)) begin
                    errors++;
                    $display("FAIL %s reg_alu got alu=%0d for kind %s", name, Aluctrl, k.name());
                end
            end
            if (AluSrcB == 2'b10) begin
                n_imm++;
                checks++;
                if (!AluSrcA || ExtOp !== ((k == K_ORI) ? EXT_ZERO : EXT_SIGNED) ||
                    Aluctrl !== ((k == K_ORI) ? ALU_OR : ALU_ADD)) begin
                    errors++;
                    $display("FAIL %s imm_alu got A=%b ext=%b alu=%0d for kind %s",
                             name, AluSrcA, ExtOp, Aluctrl, k.name());
                end
            end
            if (c > 0) begin
                checks++;
                if (illegal !== 1'b0) begin
                    errors++;
                    $display("FAIL %s illegal_idle cyc%0d got 1 want 0", name, c);
                end
            end
            acc_prev = acc_now;
            rdy_prev = mem_ready;
            @(negedge clk);
        end
        if (k != K_ILL) exp_cnt = exp_cnt + 32'd1;
        checks++;
        if (n_irwr != 1 || n_regw != e_regw || n_pcwr != e_pcwr || n_pcwrc != e_pcwrc ||
            n_memw_done != e_memw_done || n_dec != 1) begin
            errors++;
            $display("FAIL %s strobes got irwr=%0d regw=%0d pcwr=%0d pcwrc=%0d memw=%0d dec=%0d want 1 %0d %0d %0d %0d 1",
                     name, n_irwr, n_regw, n_pcwr, n_pcwrc, n_memw_done, n_dec,
                     e_regw, e_pcwr, e_pcwrc, e_memw_done);
        end
        checks++;
        if (n_fetch != fw + 1 || n_memr_d != e_memr_d || n_memw_c != e_memw_c ||
            n_imm != e_imm || n_rr != e_rr) begin
            errors++;
            $display("FAIL %s phases got fetch=%0d memrd=%0d memwr=%0d imm=%0d rr=%0d want %0d %0d %0d %0d %0d",
                     name, n_fetch, n_memr_d, n_memw_c, n_imm, n_rr,
                     fw + 1, e_memr_d, e_memw_c, e_imm, e_rr);
        end
        checks++;
        if (MemR !== 1'b1 || IorD !== 1'b0 || illegal !== (k == K_ILL) || instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL %s after_%0dcyc got MemR=%b IorD=%b illegal=%b cnt=%0d want 1 0 %b %0d",
                     name, n_cyc, MemR, IorD, illegal, instr_cnt, k == K_ILL, exp_cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_async got %h want 0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL reset_idle got %h want 0", all_out);
        end
        @(negedge clk);
        checks++;
        if (MemR !== 1'b1 || IorD !== 1'b0 || AluSrcB !== 2'b01 || Aluctrl !== ALU_ADDU) begin
            errors++;
            $display("FAIL reset_fetch got MemR=%b IorD=%b B=%b alu=%0d want 1 0 01 %0d",
                     MemR, IorD, AluSrcB, Aluctrl, ALU_ADDU);
        end
    endtask

    task automatic test_addu();
        run_instr(6'b000000, 6'b100001, 0, 0, 1'b0, "addu");
    endtask

    task automatic test_lw_waits();
        run_instr(6'b100011, 6'($urandom), 2, 3, 1'b0, "lw_wait");
    endtask

    task automatic test_branch_jump();
        run_instr(6'b000100, 6'($urandom), 0, 0, 1'b1, "beq_z1");
        run_instr(6'b000100, 6'($urandom), 0, 0, 1'b0, "beq_z0");
        run_instr(6'b000010, 6'($urandom), 0, 0, 1'b0, "j");
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'($urandom), 0, 0, 1'b0, "illegal_op");
        run_instr(6'b000000, 6'b000000, 1, 0, 1'b0, "illegal_funct");
    endtask

    task automatic test_back_to_back();
        run_instr(6'b000000, 6'b100011, 0, 0, 1'b0, "b2b_subu");
        run_instr(6'b001101, 6'($urandom), 0, 0, 1'b0, "b2b_ori");
        run_instr(6'b101011, 6'($urandom), 0, 0, 1'b0, "b2b_sw");
        run_instr(6'b101011, 6'($urandom), 0, 2, 1'b0, "b2b_sw_wait");
        run_instr(6'b100011, 6'($urandom), 0, 0, 1'b0, "b2b_lw");
    endtask

    task automatic test_random();
        logic [5:0] ops[7] = '{6'b000000, 6'b000000, 6'b001101, 6'b100011,
                               6'b101011, 6'b000100, 6'b000010};
        logic [5:0] op, fn;
        int sel;
        for (int i = 0; i < 40; i++) begin
            sel = int'($urandom_range(0, 7));
            fn  = 6'($urandom);
            if (sel == 7) begin
                op = 6'b111111;
                for (int t = 0; t < 50; t++) begin
                    op = 6'($urandom);
                    if (classify(op, fn) == K_ILL) break;
                end
                if (classify(op, fn) != K_ILL) op = 6'b111111;
            end else begin
                op = ops[sel];
                if (sel == 0) fn = 6'b100001;
                if (sel == 1) fn = 6'b100011;
            end
            run_instr(op, fn, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), "random");
        end
    endtask

    task automatic test_reset_in_memwr();
        bit found = 1'b0;
        OpCode = 6'b101011;
        funct  = 6'($urandom);
        for (int c = 0; c < 20 && !found; c++) begin
            if (MemW) found = 1'b1;
            else begin
                mem_ready = 1'b1;
                @(negedge clk);
            end
        end
        mem_ready = 1'b0;
        checks++;
        if (!found || MemW !== 1'b1 || IorD !== 1'b1) begin
            errors++;
            $display("FAIL memwr_reach got MemW=%b IorD=%b want 1 1 within 20 cycles", MemW, IorD);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_cnt = '0;
        checks++;
        if (all_out !== '0) begin
            errors++;
            $display("FAIL memwr_reset got %h want 0", all_out);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (MemW !== 1'b0 || RegW !== 1'b0 || PCWr !== 1'b0 || instr_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL memwr_hold got MemW=%b RegW=%b PCWr=%b cnt=%0d want 0 0 0 0",
                     MemW, RegW, PCWr, instr_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (MemR !== 1'b1 || IorD !== 1'b0 || MemW !== 1'b0) begin
            errors++;
            $display("FAIL memwr_restart got MemR=%b IorD=%b MemW=%b want 1 0 0", MemR, IorD, MemW);
        end
        run_instr(6'b000000, 6'b100001, 0, 0, 1'b0, "post_reset_addu");
    endtask

    initial begin
        rst_n     = 1'b0;
        OpCode    = '0;
        funct     = '0;
        Zero      = 1'b0;
        mem_ready = 1'b0;
        test_reset();
        test_addu();
        test_lw_waits();
        test_branch_jump();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_in_memwr();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
